// File: rtl/k_and_s_pkg.sv
// K&S processor shared types: instruction decode, control FSM states, ALU opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: decoded_instruction_type, ctrl_state_t, ALU_* opcodes, is_branch() helper.
package k_and_s_pkg;

   typedef enum logic [3:0] {
      I_NOP,
      I_LOAD,
      I_STORE,
      I_MOVE,
      I_ADD,
      I_SUB,
      I_AND,
      I_OR,
      I_BRANCH,
      I_BZERO,
      I_BNZERO,
      I_BNEG,
      I_BNNEG,
      I_BOV,
      I_BNOV,
      I_HALT
   } decoded_instruction_type;

   typedef enum logic [3:0] {
      S_FETCH,
      S_FETCH_LATCH,
      S_DECODE,
      S_LOAD_ADDR,
      S_LOAD_WB,
      S_STORE,
      S_ALU,
      S_MOVE,
      S_BRANCH,
      S_RETIRE,
      S_HALT
   } ctrl_state_t;

   localparam logic [1:0] ALU_OR  = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b01;
   localparam logic [1:0] ALU_SUB = 2'b10;
   localparam logic [1:0] ALU_AND = 2'b11;

   function automatic logic is_branch(input decoded_instruction_type ins);
      return (ins >= I_BRANCH) && (ins <= I_BNOV);
   endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition table: decides whether the current branch instruction is taken.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: decoded_instruction + four registered flags in, taken out (0 for non-branches).
module branch_eval
   import k_and_s_pkg::*;
(
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    taken
);

   logic any_ovf;

   // Either overflow kind counts as "overflow" for BOV/BNOV.
   assign any_ovf = unsigned_overflow | signed_overflow;

   always_comb begin
      taken = 1'b0;
      case (decoded_instruction)
         I_BRANCH: taken = 1'b1;
         I_BZERO:  taken = zero_op;
         I_BNZERO: taken = ~zero_op;
         I_BNEG:   taken = neg_op;
         I_BNNEG:  taken = ~neg_op;
         I_BOV:    taken = any_ovf;
         I_BNOV:   taken = ~any_ovf;
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the K&S data_path and RAM write strobe.
// Latency: NOP 4 cycles; ALU/MOVE/STORE/branch 5; LOAD 6; HALT sticky until rst.
// Backpressure: none; one instruction at a time, fixed schedule per opcode.
// Ports: clk, rst (sync, active high); decoded_instruction + flags in; data_path strobes,
//        ram_write_enable, halt and retired_count (wraps modulo 2^RETIRE_CNT_W) out.
module control_unit
   import k_and_s_pkg::*;
#(
   parameter int RETIRE_CNT_W = 16
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic [1:0]              operation,
   output logic                    write_reg_enable,
   output logic                    flags_reg_enable,
   output logic                    ram_write_enable,
   output logic                    halt,
   output logic [RETIRE_CNT_W-1:0] retired_count
);

   ctrl_state_t state;
   ctrl_state_t next_state;
   logic        taken;

   branch_eval u_branch_eval (
      .decoded_instruction (decoded_instruction),
      .zero_op             (zero_op),
      .neg_op              (neg_op),
      .unsigned_overflow   (unsigned_overflow),
      .signed_overflow     (signed_overflow),
      .taken               (taken)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_FETCH;
         retired_count <= '0;
      end else begin
         state <= next_state;
         if (state == S_RETIRE) begin
            retired_count <= retired_count + RETIRE_CNT_W'(1);
         end
      end
   end

   always_comb begin
      next_state       = state;
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = ALU_OR;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halt             = 1'b0;

      // Strobes are suppressed while rst is high so an interrupted STORE
      // cannot write RAM in the reset cycle.
      if (!rst) begin
         case (state)
            S_FETCH: begin
               next_state = S_FETCH_LATCH;
            end
            S_FETCH_LATCH: begin
               ir_enable  = 1'b1;
               pc_enable  = 1'b1;
               next_state = S_DECODE;
            end
            S_DECODE: begin
               case (decoded_instruction)
                  I_LOAD:                    next_state = S_LOAD_ADDR;
                  I_STORE:                   next_state = S_STORE;
                  I_ADD, I_SUB, I_AND, I_OR: next_state = S_ALU;
                  I_MOVE:                    next_state = S_MOVE;
                  I_HALT:                    next_state = S_HALT;
                  I_NOP:                     next_state = S_RETIRE;
                  default: begin
                     next_state = is_branch(decoded_instruction) ? S_BRANCH : S_RETIRE;
                  end
               endcase
            end
            S_LOAD_ADDR: begin
               addr_sel   = 1'b1;
               next_state = S_LOAD_WB;
            end
            S_LOAD_WB: begin
               // RAM data for the operand address arrives this cycle.
               addr_sel         = 1'b1;
               write_reg_enable = 1'b1;
               next_state       = S_RETIRE;
            end
            S_STORE: begin
               addr_sel         = 1'b1;
               ram_write_enable = 1'b1;
               next_state       = S_RETIRE;
            end
            S_ALU: begin
               c_sel            = 1'b1;
               write_reg_enable = 1'b1;
               flags_reg_enable = 1'b1;
               case (decoded_instruction)
                  I_ADD:   operation = ALU_ADD;
                  I_SUB:   operation = ALU_SUB;
                  I_AND:   operation = ALU_AND;
                  default: operation = ALU_OR;
               endcase
               next_state = S_RETIRE;
            end
            S_MOVE: begin
               // OR passes the source through; flags stay untouched.
               c_sel            = 1'b1;
               write_reg_enable = 1'b1;
               next_state       = S_RETIRE;
            end
            S_BRANCH: begin
               // Not-taken needs no PC update: it was already incremented in fetch.
               pc_enable  = taken;
               branch     = taken;
               next_state = S_RETIRE;
            end
            S_RETIRE: begin
               next_state = S_FETCH;
            end
            S_HALT: begin
               halt       = 1'b1;
               next_state = S_HALT;
            end
            default: begin
               next_state = S_FETCH;
            end
         endcase
      end
   end

endmodule
